// File: rtl/pwm_pkg.sv
// Shared constants and types for count_pwm_gen and other counter consumers.
// PWM_WRAP_IRQ_EN (optional macro) adds the wrap_irq pulse output on the top.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W    = 4;
  localparam int unsigned PWM_DUTY_MAX = 2 ** PWM_CNT_W;

  typedef logic [PWM_CNT_W:0] duty_t;

endpackage

// File: rtl/count_pwm_gen_if.sv
// Duty-load valid/ready handshake between software-side logic and the PWM.
interface count_pwm_gen_if
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_CNT_W
);

  logic [WIDTH:0] duty_in;
  logic           duty_valid;
  logic           duty_ready;

  modport master (output duty_in, output duty_valid, input duty_ready);
  modport slave  (input duty_in, input duty_valid, output duty_ready);

endinterface

// File: rtl/count_wrap_detect.sv
// Detects the all-ones -> zero transition of a free-running up counter.
// Holds, reloads or jumps to zero are deliberately not reported as wraps.
module count_wrap_detect
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  output logic             wrap
);

  logic [WIDTH-1:0] prev_cnt;

  // Previous count; resets to all ones so the first zero after reset is a wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_cnt <= '1;
    end else begin
      prev_cnt <= count_in;
    end
  end

  // Wrap only on a genuine max -> zero step.
  always_comb begin
    wrap = (count_in == '0) && (prev_cnt == '1);
  end

endmodule

// File: rtl/count_pwm_gen.sv
// PWM generator driven by an upstream free-running counter. Period is one
// full counter cycle; new duty values are shadowed and applied only at wrap.
// Optional: define PWM_WRAP_IRQ_EN to add the registered wrap_irq pulse.
module count_pwm_gen
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     count_in,
  count_pwm_gen_if.slave       duty_bus,
`ifdef PWM_WRAP_IRQ_EN
  output logic                 wrap_irq,
`endif
  output logic                 pwm_out
);

  localparam int unsigned DW = WIDTH + 1;
  localparam logic [DW-1:0] DUTY_MAX = {1'b1, {WIDTH{1'b0}}};

  logic          wrap;
  logic [DW-1:0] active_duty;
  logic [DW-1:0] pending_duty;
  logic          pending;
  logic [DW-1:0] duty_clamped;
  logic [DW-1:0] duty_sel;
  logic [DW-1:0] count_ext;
  logic          xfer;
  logic          apply;

  count_wrap_detect #(
    .WIDTH (WIDTH)
  ) u_wrap (
    .clk      (clk),
    .rst      (rst),
    .count_in (count_in),
    .wrap     (wrap)
  );

  // Handshake, clamp, and selection of the duty used for this cycle's compare.
  always_comb begin
    duty_bus.duty_ready = ~pending;
    xfer                = duty_bus.duty_valid && !pending;
    apply               = wrap && pending;
    duty_clamped        = (duty_bus.duty_in > DUTY_MAX) ? DUTY_MAX : duty_bus.duty_in;
    duty_sel            = apply ? pending_duty : active_duty;
    count_ext           = {1'b0, count_in};
  end

  // Shadow register: one-entry holding slot, promoted to active at wrap.
  // xfer and apply are exclusive since xfer requires pending == 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_duty  <= '0;
      pending_duty <= '0;
      pending      <= 1'b0;
    end else begin
      if (apply) begin
        active_duty <= pending_duty;
        pending     <= 1'b0;
      end
      if (xfer) begin
        pending_duty <= duty_clamped;
        pending      <= 1'b1;
      end
    end
  end

  // Registered compare; WIDTH+1 bits so duty 2^WIDTH is constant high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (count_ext < duty_sel);
    end
  end

`ifdef PWM_WRAP_IRQ_EN
  // One-cycle pulse aligned with the first pwm_out of each new period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_irq <= 1'b0;
    end else begin
      wrap_irq <= wrap;
    end
  end
`endif

endmodule

// File: tb/tb_count_pwm_gen.sv
// Scoreboard bench for count_pwm_gen: stimulus pushes expected outputs per
// cycle, a monitor pops and compares one entry after every rising edge.
module tb_count_pwm_gen;
  import pwm_pkg::*;

  typedef struct packed {
    logic pwm;
    logic rdy;
    logic irq;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic [PWM_CNT_W-1:0] count_in;
  logic                 pwm_out;
`ifdef PWM_WRAP_IRQ_EN
  logic                 wrap_irq;
`endif

  count_pwm_gen_if #(.WIDTH(PWM_CNT_W)) bus ();

  count_pwm_gen #(
    .WIDTH (PWM_CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .count_in (count_in),
    .duty_bus (bus),
`ifdef PWM_WRAP_IRQ_EN
    .wrap_irq (wrap_irq),
`endif
    .pwm_out  (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];

  // Spec-level bookkeeping of the handshake slot and the wrap condition.
  logic [3:0] tb_prev = 4'hF;
  logic       tb_pend = 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus; exp_duty is the duty the period is meant to show.
  task automatic step(input logic [3:0] c, input logic v, input logic [4:0] d,
                      input int exp_duty);
    exp_t e;
    logic wrap_e;
    logic acc;
    @(negedge clk);
    rst            = 1'b1;
    count_in       = c;
    bus.duty_valid = v;
    bus.duty_in    = d;
    wrap_e = (c == 4'd0) && (tb_prev == 4'hF);
    acc    = v && !tb_pend;
    if (wrap_e && tb_pend) tb_pend = 1'b0;
    if (acc) tb_pend = 1'b1;
    tb_prev = c;
    e.pwm = (int'(c) < exp_duty);
    e.rdy = !tb_pend;
    e.irq = wrap_e;
    q.push_back(e);
  endtask

  // Full period with a valid mask; va used before index split, vb after.
  task automatic period(input int exp_duty, input logic [15:0] vmask,
                        input logic [4:0] va, input logic [4:0] vb, input int split);
    for (int i = 0; i < 16; i++)
      step(4'(i), vmask[i], (i < split) ? va : vb, exp_duty);
  endtask

  // Counts lo..hi with an optional single-cycle load at count ld_at.
  task automatic span(input int lo, input int hi, input int exp_duty,
                      input int ld_at, input logic [4:0] ld_val);
    for (int i = lo; i <= hi; i++)
      step(4'(i), i == ld_at, (i == ld_at) ? ld_val : 5'd0, exp_duty);
  endtask

  // One clock held in reset; outputs must clear asynchronously.
  task automatic rst_cycle(input logic [3:0] c);
    exp_t e;
    @(negedge clk);
    rst            = 1'b0;
    count_in       = c;
    bus.duty_valid = 1'b0;
    bus.duty_in    = '0;
    tb_prev        = 4'hF;
    tb_pend        = 1'b0;
    e.pwm = 1'b0;
    e.rdy = 1'b1;
    e.irq = 1'b0;
    q.push_back(e);
    #1;
    chk("rst_async_pwm", pwm_out, 1'b0);
    chk("rst_async_ready", bus.duty_ready, 1'b1);
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pwm_out", pwm_out, e.pwm);
        chk("duty_ready", bus.duty_ready, e.rdy);
`ifdef PWM_WRAP_IRQ_EN
        chk("wrap_irq", wrap_irq, e.irq);
`endif
      end
    end
  end

  initial begin
    rst            = 1'b0;
    count_in       = '0;
    bus.duty_valid = 1'b0;
    bus.duty_in    = '0;
    #2;
    chk("reset_pwm", pwm_out, 1'b0);
    chk("reset_ready", bus.duty_ready, 1'b1);
    rst_cycle(4'd14);
    rst_cycle(4'd15);

    // Free-running with no load: constant low, always ready.
    period(0, 16'h0000, 5'd0, 5'd0, 0);
    period(0, 16'h0000, 5'd0, 5'd0, 0);

    // Load 5 mid-period: takes effect on the next whole period.
    span(0, 15, 0, 7, 5'd5);
    period(5, 16'h0000, 5'd0, 5'd0, 0);
    period(5, 16'h0000, 5'd0, 5'd0, 0);

    // Duty 0 then 16: constant low, constant high.
    span(0, 15, 5, 3, 5'd0);
    span(0, 15, 0, 10, 5'd16);
    period(16, 16'h0000, 5'd0, 5'd0, 0);

    // 31 clamps to 16 (checked via a visible 2 -> 16 transition).
    span(0, 15, 16, 2, 5'd2);
    span(0, 15, 2, 5, 5'd31);
    period(16, 16'h0000, 5'd0, 5'd0, 0);

    // Load accepted on the wrap cycle applies at the following wrap.
    span(0, 15, 16, 0, 5'd8);
    period(8, 16'h0000, 5'd0, 5'd0, 0);

    // 3 accepted, 9 held while pending, 9 accepted once ready returns.
    period(8, 16'b1111_1111_1101_0000, 5'd3, 5'd9, 5);
    period(3, 16'hFFFF, 5'd9, 5'd9, 0);
    period(9, 16'h0000, 5'd0, 5'd0, 0);

    // Jump 5->0 and hold at 0 are not wraps: pending 7 waits for a real wrap.
    span(0, 15, 9, 3, 5'd12);
    period(12, 16'h0000, 5'd0, 5'd0, 0);
    span(0, 5, 12, 2, 5'd7);
    step(4'd0, 1'b0, 5'd0, 12);
    step(4'd0, 1'b0, 5'd0, 12);
    span(1, 15, 12, -1, 5'd0);
    period(7, 16'h0000, 5'd0, 5'd0, 0);

    // Reset mid-period with 12 active and 7 pending: everything clears.
    span(0, 15, 7, 3, 5'd12);
    span(0, 8, 12, 4, 5'd7);
    rst_cycle(4'd9);
    rst_cycle(4'd10);
    span(11, 15, 0, -1, 5'd0);
    period(0, 16'h0000, 5'd0, 5'd0, 0);
    period(0, 16'h0000, 5'd0, 5'd0, 0);

    @(negedge clk);
    bus.duty_valid = 1'b0;
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    chk("scoreboard_drained", q.size() == 0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
